seq_mul_radix: RTL and testbench

- Parametrised multi-cycle integer multiplier for the TRM core.
- Retires STEP multiplier bits per clock.
- Supports signed (two's complement) and unsigned operands, selected per operation.
- Captures its operands on the first cycle, so the core may change A/B while stalled.
- Sits beside the ALU; the core holds the multiply instruction while stall is high.

---
 rtl/seq_mul_radix.sv | 116 +++++++++++
 tb/tb_seq_mul_radix.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_mul_radix.sv
// seq_mul_radix: multi-cycle integer multiplier that retires STEP multiplier bits per clock.
// Supports signed (two's complement) or unsigned operands, selected per operation.
// Operands are captured in the start cycle, so the core may change A/B/sgn while stalled.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   mul    - multiply request, held high until stall is low
//   sgn    - 1 = signed operands, 0 = unsigned (start cycle only)
//   A      - multiplier (start cycle only)
//   B      - multiplicand (start cycle only)
//   stall  - high while the result for the current request is not yet available
//   mulRes - product {Hi, Lo}, valid in the cycle stall falls
//
// Parameters: DW must be a multiple of STEP and at least 8; STEP is 1, 2 or 4.
module seq_mul_radix #(
  parameter int unsigned DW   = 32,
  parameter int unsigned STEP = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul,
  input  logic            sgn,
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  output logic            stall,
  output logic [2*DW-1:0] mulRes
);

  localparam int unsigned N  = DW / STEP;
  localparam int unsigned CW = $clog2(N + 1);
  // The partial sum is nominally DW+STEP+1 bits wide, but its top bit never reaches Hi or Lo;
  // modular arithmetic at DW+STEP bits yields identical retained bits.
  localparam int unsigned PW = DW + STEP;
  localparam int          LastBit = int'(STEP) - 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [DW-1:0]   hi_q, lo_q, b_q;
  logic            sgn_q;
  logic [CW-1:0]   cnt_q;

  logic            last_step;
  logic [PW-1:0]   bx, hix, acc;
  logic [DW-1:0]   hi_d, lo_d;

  assign last_step = (cnt_q == CW'(N - 1));

  // One radix-2^STEP step: acc = Hi + d*B via shifted adds. On the final signed step the
  // digit's MSB carries negative weight, so its partial product is subtracted instead.
  always_comb begin
    bx  = sgn_q ? {{STEP{b_q[DW-1]}}, b_q}  : {{STEP{1'b0}}, b_q};
    hix = sgn_q ? {{STEP{hi_q[DW-1]}}, hi_q} : {{STEP{1'b0}}, hi_q};
    acc = hix;
    for (int i = 0; i < int'(STEP); i++) begin
      if (lo_q[i]) begin
        if (sgn_q && last_step && (i == LastBit)) begin
          acc = acc - (bx << i);
        end else begin
          acc = acc + (bx << i);
        end
      end
    end
    hi_d = acc[DW+STEP-1:STEP];
    lo_d = {acc[STEP-1:0], lo_q[DW-1:STEP]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mul) begin
            b_q     <= B;
            sgn_q   <= sgn;
            hi_q    <= '0;
            lo_q    <= A;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (!mul) begin
            // Request withdrawn: abandon the operation.
            state_q <= StIdle;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Stall follows the request until the DONE cycle; reset forces it low immediately.
  assign stall  = !rst && mul && (state_q != StDone);
  assign mulRes = {hi_q, lo_q};

endmodule

// File: tb/tb_seq_mul_radix.sv
module tb_seq_mul_radix;

  logic        clk;
  logic        rst;
  logic        mul_s   [3];
  logic        sgn_s   [3];
  logic [31:0] a_s     [3];
  logic [31:0] b_s     [3];
  logic        stall_w [3];
  logic [63:0] res_w   [3];

  int n_vec;
  int n_err;

  seq_mul_radix #(.DW(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .mul(mul_s[0]), .sgn(sgn_s[0]), .A(a_s[0]), .B(b_s[0]),
    .stall(stall_w[0]), .mulRes(res_w[0])
  );

  seq_mul_radix #(.DW(32), .STEP(2)) u_dut2 (
    .clk(clk), .rst(rst), .mul(mul_s[1]), .sgn(sgn_s[1]), .A(a_s[1]), .B(b_s[1]),
    .stall(stall_w[1]), .mulRes(res_w[1])
  );

  seq_mul_radix #(.DW(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .mul(mul_s[2]), .sgn(sgn_s[2]), .A(a_s[2]), .B(b_s[2]),
    .stall(stall_w[2]), .mulRes(res_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps per operation for each instance (STEP = 1, 2, 4).
  function automatic int n_of(input int k);
    case (k)
      0:       return 32;
      1:       return 16;
      default: return 8;
    endcase
  endfunction

  // Called just after a falling edge. Starts an operation, counts stall-high cycles, optionally
  // swaps the inputs after chg_at stall cycles, then checks stall length and result.
  task automatic run_op(input int k, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input string tag, input int chg_at,
                        input logic [31:0] ca, input logic [31:0] cb, input logic cs,
                        input bit keep);
    int cnt;
    cnt = 0;
    sgn_s[k] = sg;
    a_s[k]   = a;
    b_s[k]   = b;
    mul_s[k] = 1'b1;
    forever begin
      #1;
      if (!stall_w[k]) break;
      if (cnt == chg_at) begin
        a_s[k]   = ca;
        b_s[k]   = cb;
        sgn_s[k] = cs;
      end
      cnt++;
      if (cnt > 100) break;
      @(negedge clk);
    end
    check_eq({tag, ".stall"}, 64'(cnt), 64'(n_of(k) + 1));
    check_eq({tag, ".res"}, res_w[k], exp_res);
    if (!keep) mul_s[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0]        ra, rb;
    logic               rs;
    logic signed [63:0] sa, sb;
    logic [63:0]        rexp;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mul_s[k] = 1'b1;
      sgn_s[k] = 1'b0;
      a_s[k]   = '0;
      b_s[k]   = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_stall", {63'd0, stall_w[k]}, 64'd0);
      check_eq("rst_res", res_w[k], 64'd0);
      mul_s[k] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed products at STEP=2.
    run_op(1, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "s_m3x5", -1, 0, 0, 0, 0);
    #1 check_eq("hold", res_w[1], 64'hFFFF_FFFF_FFFF_FFF1);
    @(negedge clk);
    run_op(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "u_max", -1, 0, 0, 0, 0);

    // Signed corner cases on every STEP.
    for (int k = 0; k < 3; k++) begin
      run_op(k, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "s_minxmin",
             -1, 0, 0, 0, 0);
      run_op(k, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "s_minxm1",
             -1, 0, 0, 0, 0);
    end

    // Inputs change mid-flight; mul held through DONE starts the next op on the new inputs.
    run_op(1, 1'b0, 32'd7, 32'd6, 64'd42, "chg_7x6", 2, 32'h0001_2345, 32'hFFFF_FFFE, 1'b1, 1);
    run_op(1, 1'b1, 32'h0001_2345, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFD_B976, "b2b",
           -1, 0, 0, 0, 0);

    // Withdraw the request in BUSY cycle 5, then a fresh request.
    sgn_s[1] = 1'b0;
    a_s[1]   = 32'd9;
    b_s[1]   = 32'd9;
    mul_s[1] = 1'b1;
    repeat (6) @(negedge clk);
    mul_s[1] = 1'b0;
    #1 check_eq("abort_stall", {63'd0, stall_w[1]}, 64'd0);
    @(negedge clk);
    run_op(1, 1'b0, 32'd2, 32'd3, 64'd6, "after_abort", -1, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an operation.
    sgn_s[2] = 1'b0;
    a_s[2]   = 32'hFFFF_FFFF;
    b_s[2]   = 32'hFFFF_FFFF;
    mul_s[2] = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_stall", {63'd0, stall_w[2]}, 64'd0);
    check_eq("arst_res", res_w[2], 64'd0);
    @(negedge clk);
    mul_s[2] = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    run_op(2, 1'b1, 32'd100, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FD44, "after_rst",
           -1, 0, 0, 0, 0);

    // Random operands against a wide reference product.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 150; i++) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        sa = {{32{ra[31]}}, ra};
        sb = {{32{rb[31]}}, rb};
        rexp = rs ? 64'(sa * sb) : ({32'd0, ra} * {32'd0, rb});
        run_op(k, rs, ra, rb, rexp, "rand", -1, 0, 0, 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
